// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button debouncer.
// Channel FSM states and counter sizing.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM_P,
    HELD,
    ARM_R
  } btn_state_t;

  // Bits needed to hold 0..n inclusive; never below one bit.
  function automatic int cnt_width(input int n);
    if (n < 1) return 1;
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-FF synchroniser, debounce FSM,
// debounce counter and long-press counter.
module debounce_chan
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20000,
  parameter int LONG_CYC     = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic pressed_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  if (DEBOUNCE_CYC < 1) begin : g_bad_deb
    $error("debounce_chan: DEBOUNCE_CYC must be >= 1");
  end
  if (LONG_CYC < 1) begin : g_bad_long
    $error("debounce_chan: LONG_CYC must be >= 1");
  end

  localparam int DW = cnt_width(DEBOUNCE_CYC);
  localparam int LW = cnt_width(LONG_CYC);

  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [LW-1:0] LMAX  = LW'(LONG_CYC);
  localparam logic [LW-1:0] LLAST = LW'(LONG_CYC - 1);

  // A single differing cycle completes the debounce.
  localparam bit ONE_CYC = (DEBOUNCE_CYC == 1);

  logic sync1_q;
  logic sync2_q;

  btn_state_t state_q, state_d;

  logic [DW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;

  logic press_q, press_d;
  logic rel_q, rel_d;
  logic long_q, long_d;

  // Synchroniser; resets to the released value so a
  // button held through reset is seen as a fresh press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pressed_i;
      sync2_q <= sync1_q;
    end
  end

  // State, counters and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lcnt_q  <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lcnt_q  <= lcnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  // Next-state: the cycle that first sees the new level
  // counts as the first of the DEBOUNCE_CYC stable cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lcnt_d  = lcnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d  = '0;
        lcnt_d = '0;
        if (sync2_q) begin
          if (ONE_CYC) begin
            state_d = HELD;
            press_d = 1'b1;
          end else begin
            state_d = ARM_P;
            cnt_d   = DW'(1);
          end
        end
      end
      ARM_P: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DLAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      HELD: begin
        cnt_d = '0;
        if (sync2_q) begin
          // Saturating long counter; strobes once.
          if (lcnt_q != LMAX) begin
            lcnt_d = lcnt_q + LW'(1);
            long_d = (lcnt_q == LLAST);
          end
        end else if (ONE_CYC) begin
          state_d = IDLE;
          lcnt_d  = '0;
          rel_d   = 1'b1;
        end else begin
          state_d = ARM_R;
          cnt_d   = DW'(1);
        end
      end
      ARM_R: begin
        // Long counter holds here; a bounce back to
        // HELD must not re-arm the long strobe.
        if (sync2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DLAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          lcnt_d  = '0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        lcnt_d  = '0;
      end
    endcase
  end

  assign level_o   = (state_q == HELD) || (state_q == ARM_R);
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign long_o    = long_q;

endmodule

// File: rtl/btn_debounce.sv
// Debounced push-button front end: polarity fix-up
// and one independent debounce channel per pin.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int BTN_NR       = 2,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = 20000,
  parameter int LONG_CYC     = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BTN_NR-1:0] btn_in,
  output logic [BTN_NR-1:0] btn_level,
  output logic [BTN_NR-1:0] btn_press,
  output logic [BTN_NR-1:0] btn_release,
  output logic [BTN_NR-1:0] btn_long
);

  if (DEBOUNCE_CYC < 1) begin : g_bad_deb
    $error("btn_debounce: DEBOUNCE_CYC must be >= 1");
  end
  if (LONG_CYC < 1) begin : g_bad_long
    $error("btn_debounce: LONG_CYC must be >= 1");
  end

  // 1 = pressed, regardless of board wiring.
  logic [BTN_NR-1:0] pressed;

  assign pressed = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

  for (genvar i = 0; i < BTN_NR; i++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .pressed_i(pressed[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .long_o   (btn_long[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: per-cycle vector
// table plus hand sequences for reset and latency.
module tb_btn_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_in;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;
  logic [1:0] btn_long;

  int passed = 0;
  int total  = 0;

  btn_debounce #(
    .BTN_NR      (2),
    .ACTIVE_LOW  (1),
    .DEBOUNCE_CYC(4),
    .LONG_CYC    (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_long   (btn_long)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] btn;
    logic [1:0] lvl;
    logic [1:0] pr;
    logic [1:0] rl;
    logic [1:0] lg;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  task automatic run(input int n, input logic [1:0] b,
                     input logic [1:0] lvl, input logic [1:0] pr,
                     input logic [1:0] rl, input logic [1:0] lg,
                     input string tag);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v.btn = b;
      v.lvl = lvl;
      v.pr  = pr;
      v.rl  = rl;
      v.lg  = lg;
      v.tag = tag;
      vecs.push_back(v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] outs();
    return {btn_level, btn_press, btn_release, btn_long};
  endfunction

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b want %b", name, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   found;
    logic bad;

    rst    = 1'b1;
    btn_in = 2'b11;
    repeat (3) step();
    check("reset_state", outs(), 8'h00);
    rst = 1'b0;

    // Released pins after reset: silent.
    run(30, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, "idle");

    // 3-cycle glitch on ch0 is rejected.
    run(3,  2'b10, 2'b00, 2'b00, 2'b00, 2'b00, "glitch");
    run(10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, "glitch_q");

    // Clean ch0 press, long at +10, release 6 after pin rises.
    run(6,  2'b10, 2'b00, 2'b00, 2'b00, 2'b00, "p0_arm");
    run(1,  2'b10, 2'b01, 2'b01, 2'b00, 2'b00, "p0_press");
    run(9,  2'b10, 2'b01, 2'b00, 2'b00, 2'b00, "p0_held");
    run(1,  2'b10, 2'b01, 2'b00, 2'b00, 2'b01, "p0_long");
    run(13, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, "p0_sat");
    run(6,  2'b11, 2'b01, 2'b00, 2'b00, 2'b00, "p0_armr");
    run(1,  2'b11, 2'b00, 2'b00, 2'b01, 2'b00, "p0_rel");
    run(8,  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, "p0_idle");

    // Bouncy ch0: toggles every 2 cycles, then settles low.
    for (int k = 0; k < 3; k++) begin
      run(2, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, "bnc_lo");
      run(2, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, "bnc_hi");
    end
    run(6,  2'b10, 2'b00, 2'b00, 2'b00, 2'b00, "bnc_arm");
    run(1,  2'b10, 2'b01, 2'b01, 2'b00, 2'b00, "bnc_press");
    run(9,  2'b10, 2'b01, 2'b00, 2'b00, 2'b00, "bnc_held");
    run(1,  2'b10, 2'b01, 2'b00, 2'b00, 2'b01, "bnc_long");
    run(1,  2'b10, 2'b01, 2'b00, 2'b00, 2'b00, "bnc_held2");
    run(6,  2'b11, 2'b01, 2'b00, 2'b00, 2'b00, "bnc_armr");
    run(1,  2'b11, 2'b00, 2'b00, 2'b01, 2'b00, "bnc_rel");
    run(8,  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, "bnc_idle");

    // Ch1: long fires, release glitch does not re-arm it.
    run(6,  2'b01, 2'b00, 2'b00, 2'b00, 2'b00, "c1_arm");
    run(1,  2'b01, 2'b10, 2'b10, 2'b00, 2'b00, "c1_press");
    run(9,  2'b01, 2'b10, 2'b00, 2'b00, 2'b00, "c1_held");
    run(1,  2'b01, 2'b10, 2'b00, 2'b00, 2'b10, "c1_long");
    run(3,  2'b01, 2'b10, 2'b00, 2'b00, 2'b00, "c1_sat");
    run(2,  2'b11, 2'b10, 2'b00, 2'b00, 2'b00, "c1_glitch");
    run(19, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, "c1_norearm");
    run(6,  2'b11, 2'b10, 2'b00, 2'b00, 2'b00, "c1_armr");
    run(1,  2'b11, 2'b00, 2'b00, 2'b10, 2'b00, "c1_rel");
    run(8,  2'b11, 2'b00, 2'b00, 2'b00, 2'b00, "c1_idle");

    foreach (vecs[i]) begin
      btn_in = vecs[i].btn;
      check($sformatf("%s[%0d]", vecs[i].tag, i), outs(),
            {vecs[i].lvl, vecs[i].pr, vecs[i].rl, vecs[i].lg});
      step();
    end

    // Both pressed together, then reset mid-HELD.
    btn_in = 2'b00;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("both_arm[%0d]", k), outs(), 8'h00);
      step();
    end
    check("both_press", outs(), {2'b11, 2'b11, 2'b00, 2'b00});
    repeat (4) step();
    check("both_held", outs(), {2'b11, 2'b00, 2'b00, 2'b00});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_clear", outs(), 8'h00);

    found = -1;
    bad   = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (btn_press != 2'b00) begin
        found = k;
        break;
      end
      if (btn_release != 2'b00 || btn_level != 2'b00)
        bad = 1'b1;
    end
    check("rst_repress_lat", 8'(found), 8'd6);
    check("rst_repress_val", 8'(btn_press), 8'(2'b11));
    check("rst_no_release", 8'(bad), 8'd0);

    // Simultaneous release of both channels.
    btn_in = 2'b11;
    found  = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (btn_release != 2'b00) begin
        found = k;
        break;
      end
    end
    check("both_rel_lat", 8'(found), 8'd6);
    check("both_rel_val", outs(), {2'b00, 2'b00, 2'b11, 2'b00});
    step();
    check("both_rel_done", outs(), 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
